// File: rtl/scan_decoder_pkg.sv
// Shared types for scan_decoder_n: FSM state encoding and mode_i encoding.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan,
    StBlank
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter for scan_decoder_n: counts held cycles, pulses step_o once the
// count reaches dwell_i (>= so a lowered dwell_i takes effect immediately).
module dwell_counter #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               step_o
);

  logic [DWELL_W-1:0] cnt_d, cnt_q;

  assign step_o = en_i && (cnt_q >= dwell_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = step_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_decoder_n.sv
// Registered N-to-2^N active-low decoder with 74138-style enables and auto-scan.
// Define SCAN_DECODER_N_BLANK_EN for a one-cycle break-before-make blank per step.
module scan_decoder_n
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [SEL_W-1:0]      select_i,
  input  logic                  g1_en_i,
  input  logic                  g2a_en_n_i,
  input  logic                  g2b_en_n_i,
  input  logic                  mode_i,
  input  logic [DWELL_W-1:0]    dwell_i,
  output logic [(2**SEL_W)-1:0] yn_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  wrap_o
);

  localparam int unsigned OUT_N = 2 ** SEL_W;
  localparam logic [OUT_N-1:0] LineOne = OUT_N'(1);

  state_e             state_d, state_q;
  logic [SEL_W-1:0]   idx_d, idx_q;
  logic [OUT_N-1:0]   yn_d, yn_q;
  logic               wrap_d, wrap_q;
  logic               en;
  logic               cnt_clr;
  logic               cnt_en;
  logic               step;

  assign en = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .dwell_i (dwell_i),
    .step_o  (step)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    yn_d    = '1;
    wrap_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (!en) begin
      state_d = StIdle;
    end else if (mode_i == MODE_DIRECT) begin
      state_d = StDirect;
      idx_d   = select_i;
      yn_d    = ~(LineOne << select_i);
    end else if (state_q == StIdle || state_q == StDirect) begin
      // Scan entry always restarts from select_i, never from the held index.
      state_d = StScan;
      idx_d   = select_i;
      cnt_clr = 1'b1;
      yn_d    = ~(LineOne << select_i);
    end else begin
      cnt_en  = 1'b1;
      state_d = StScan;
      if (step) begin
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == {SEL_W{1'b1}});
      end
      yn_d = ~(LineOne << idx_d);
`ifdef SCAN_DECODER_N_BLANK_EN
      // A step taken while already blank shows the new line directly.
      if (step && state_q == StScan) begin
        state_d = StBlank;
        yn_d    = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      yn_q    <= '1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      yn_q    <= yn_d;
      wrap_q  <= wrap_d;
    end
  end

  assign yn_o   = yn_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_scan_decoder_n.sv
// Randomised self-checking bench for scan_decoder_n against a cycle-level reference model.
// Honours SCAN_DECODER_N_BLANK_EN in the model when the design is built with it.
module tb_scan_decoder_n;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 8;

  localparam int MIdle   = 0;
  localparam int MDirect = 1;
  localparam int MScan   = 2;
  localparam int MBlank  = 3;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic [SEL_W-1:0]   select_i;
  logic               g1_en_i;
  logic               g2a_en_n_i;
  logic               g2b_en_n_i;
  logic               mode_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [7:0]         yn_o;
  logic [SEL_W-1:0]   idx_o;
  logic               wrap_o;

  int n_checks = 0;
  int n_errors = 0;

  int         m_st;
  int         m_idx;
  int         m_cnt;
  logic [7:0] m_yn;
  logic       m_wrap;

  scan_decoder_n #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .select_i   (select_i),
    .g1_en_i    (g1_en_i),
    .g2a_en_n_i (g2a_en_n_i),
    .g2b_en_n_i (g2b_en_n_i),
    .mode_i     (mode_i),
    .dwell_i    (dwell_i),
    .yn_o       (yn_o),
    .idx_o      (idx_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] line_code(input int i);
    return 8'hFF ^ (8'h01 << i);
  endfunction

  // Reference behaviour for one clock edge, from the currently applied inputs.
  task automatic model_edge();
    bit en;
    bit stepping;
    en = g1_en_i && !g2a_en_n_i && !g2b_en_n_i;
    m_wrap = 1'b0;
    if (!rst_n_i) begin
      m_st = MIdle; m_idx = 0; m_cnt = 0; m_yn = 8'hFF;
    end else if (!en) begin
      m_st = MIdle; m_yn = 8'hFF;
    end else if (!mode_i) begin
      m_st = MDirect; m_idx = int'(select_i); m_yn = line_code(m_idx);
    end else if (m_st == MIdle || m_st == MDirect) begin
      m_st = MScan; m_idx = int'(select_i); m_cnt = 0; m_yn = line_code(m_idx);
    end else begin
      stepping = (m_cnt >= int'(dwell_i));
      if (stepping) begin
        m_wrap = (m_idx == 7);
        m_idx  = (m_idx + 1) % 8;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
`ifdef SCAN_DECODER_N_BLANK_EN
      if (stepping && m_st == MScan) begin
        m_st = MBlank; m_yn = 8'hFF;
      end else begin
        m_st = MScan; m_yn = line_code(m_idx);
      end
`else
      m_st = MScan;
      m_yn = line_code(m_idx);
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_edge();
    #1;
    check("yn", 32'(yn_o), 32'(m_yn));
    check("idx", 32'(idx_o), 32'(m_idx));
    check("wrap", 32'(wrap_o), 32'(m_wrap));
    check("multi_low", 32'($countones(~yn_o) > 1), 32'd0);
  endtask

  task automatic set_en(input bit g1, input bit g2a_n, input bit g2b_n);
    g1_en_i = g1; g2a_en_n_i = g2a_n; g2b_en_n_i = g2b_n;
  endtask

  initial begin
    int guard;
    m_st = MIdle; m_idx = 0; m_cnt = 0; m_yn = 8'hFF; m_wrap = 1'b0;

    // Reset with random side inputs
    rst_n_i  = 1'b0;
    select_i = SEL_W'($urandom);
    set_en(1'($urandom), 1'($urandom), 1'($urandom));
    mode_i   = 1'($urandom);
    dwell_i  = DWELL_W'($urandom);
    repeat (2) cycle();
    check("reset_yn", 32'(yn_o), 32'hFF);
    check("reset_idx", 32'(idx_o), 32'd0);
    rst_n_i = 1'b1;

    // Enable truth table
    mode_i = 1'b0; select_i = 3'd3; dwell_i = '0;
    for (int c = 0; c < 8; c++) begin
      set_en(c[2], c[1], c[0]);
      cycle();
    end

    // Direct sweep
    set_en(1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) begin
      select_i = SEL_W'(s);
      cycle();
    end
    cycle();

    // Scan from 6 with dwell 2
    mode_i = 1'b1; select_i = 3'd6; dwell_i = 8'd2;
    repeat (12) cycle();

    // Disable mid-scan at index 2, then re-enable from 5
    guard = 0;
    while (m_idx != 2 && guard < 64) begin
      cycle();
      guard++;
    end
    check("reach_idx2", 32'(m_idx), 32'd2);
    g1_en_i = 1'b0;
    repeat (5) cycle();
    g1_en_i = 1'b1; select_i = 3'd5;
    repeat (12) cycle();

    // Fastest scan (alternates with blank cycles when blanking is built in)
    dwell_i = 8'd0; mode_i = 1'b0;
    cycle();
    mode_i = 1'b1; select_i = 3'd0;
    repeat (20) cycle();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rst_n_i  = ($urandom_range(0, 99) >= 2);
      set_en($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) mode_i = ~mode_i;
      dwell_i  = DWELL_W'($urandom_range(0, 3));
      select_i = SEL_W'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_decoder_n.md
Name: scan_decoder_n

Overview:
- Parametrised, registered N-to-2^N line decoder with active-low outputs and 74138-style three-input enable gating (G1, /G2A, /G2B).
- Adds an auto-scan mode: an internal index counter steps through all outputs with a programmable dwell time, for multiplexed display and keypad strobing.
- Sits between control logic and the multiplexed I/O strobe lines.

Parameters:
- SEL_W, 3, select/index width; output count OUT_N = 2**SEL_W (localparam, not overridable).
- DWELL_W, 8, width of the dwell-time input and the internal dwell counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- select_i  in  SEL_W  line select in direct mode; start index on entry to scan mode.
- g1_en_i  in  1  active-high enable.
- g2a_en_n_i  in  1  active-low enable.
- g2b_en_n_i  in  1  active-low enable.
- mode_i  in  1  0 = direct decode, 1 = auto-scan.
- dwell_i  in  DWELL_W  number of extra cycles each line is held in scan mode (0 = step every cycle).
- yn_o  out  OUT_N  registered active-low decoded lines.
- idx_o  out  SEL_W  registered current index (selected line).
- wrap_o  out  1  one-cycle pulse when the scan index wraps from OUT_N-1 to 0.

Behaviour:
- Reset: sampled only at a clk_i edge with rst_n_i=0. Reset values: yn_o all ones, idx_o 0, wrap_o 0, dwell counter 0, FSM in IDLE. Reset overrides every other input in the same cycle.
- en = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i, evaluated combinationally from the inputs and sampled at each clock edge.
- FSM states: IDLE, DIRECT, SCAN (plus BLANK with the optional feature).
  - Any state, en=0: go to IDLE. yn_o = all ones; idx_o and the dwell counter hold; wrap_o = 0.
  - IDLE/SCAN, en=1, mode_i=0: go to DIRECT.
  - IDLE/DIRECT, en=1, mode_i=1: go to SCAN. On this entry edge, idx_o loads select_i and the dwell counter clears.
- DIRECT mode:
  - idx_o <= select_i.
  - yn_o <= ~(1 << select_i). Exactly one bit is low.
  - Latency is 1 cycle from input to yn_o.
- SCAN mode:
  - yn_o = ~(1 << idx_o), registered, so exactly one bit is low.
  - Each cycle: if cnt >= dwell_i, then cnt <= 0 and idx_o <= idx_o+1 (modulo OUT_N); otherwise cnt <= cnt+1.
  - Because the comparison is >=, lowering dwell_i mid-count takes effect immediately.
  - Each line is held for dwell_i+1 cycles.
  - wrap_o = 1 for exactly the one cycle in which idx_o becomes 0 through an increment. A load from select_i never raises wrap_o.
- Re-enable after IDLE: returning to SCAN with mode_i=1 reloads idx_o from select_i. Scan does not resume from the held value.
- Mode change while enabled: SCAN to DIRECT takes effect at the next edge. DIRECT to SCAN loads select_i as described above.
- Bench contract: select_i, dwell_i and mode_i are driven with known values (no X/Z) whenever en=1. X/Z behaviour is undefined.

Optional Feature:
- Macro: SCAN_DECODER_N_BLANK_EN.
- Defined: break-before-make blanking. On every scan index step, the FSM enters BLANK for exactly one cycle with yn_o = all ones; idx_o has already advanced. The new line asserts on the following cycle. The dwell counter continues running during BLANK, so the step period is unchanged at dwell_i+1 cycles. With dwell_i=0, lines alternate with the blank cycle. en=0 during BLANK goes to IDLE.
- Undefined: no BLANK state. Lines switch directly from one to the next.

Decomposition:
- Package scan_decoder_pkg: the state enum type (IDLE, DIRECT, SCAN, BLANK) and the mode encoding constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
- One sub-module: dwell_counter (parametrised by DWELL_W). It takes clear/enable, compares the count against dwell_i, and outputs a step pulse.
- Decode and FSM stay in the top module.

Test Plan (SEL_W=3, DWELL_W=8):
- Reset: rst_n_i=0 for 2 cycles, all other inputs random -> yn_o=8'hFF, idx_o=0, wrap_o=0.
- Enable truth table: each of the 8 enable combinations with mode_i=0, select_i=3 -> only G1=1, /G2A=0, /G2B=0 gives yn_o=8'hF7 one cycle later; all others give 8'hFF.
- Direct sweep: select_i = 0..7 with one value per cycle -> yn_o = FE, FD, FB, F7, EF, DF, BF, 7F, each lagging select_i by 1 cycle.
- Scan: mode_i=1, select_i=6, dwell_i=2 -> idx_o = 6,6,6,7,7,7,0,..., with wrap_o high only on the first cycle of idx_o=0; each line is held 3 cycles.
- Disable mid-scan: g1_en_i=0 for 5 cycles at idx_o=2 -> yn_o=8'hFF and idx_o holds 2. On re-enable with select_i=5, the scan restarts at idx_o=5.
- Blank build with SCAN_DECODER_N_BLANK_EN defined and dwell_i=0 -> yn_o alternates 8'hFF with the next line's code; there is never more than one bit low, and the step period is 1 cycle.
